// File: rtl/aes_pkg.sv
// Shared types and constants for the AES round-datapath scheduler.
package aes_pkg;

    localparam int RND_SIZE = 128;
    localparam int NUM_RND  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sched_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/aes_rr_arb.sv
// Two-way round-robin arbiter; the requester that did not win last time wins a tie.
module aes_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] grant,
    output logic       upd
);
    import aes_pkg::*;

    req_id_t    last_grant_r;
    logic [1:0] grant_s;

    // Grant selection: single requester wins outright, tie goes away from last_grant.
    always_comb begin
        grant_s = 2'b00;
        if (!en) begin
            grant_s = 2'b00;
        end else if (req == 2'b11) begin
            grant_s = last_grant_r ? 2'b01 : 2'b10;
        end else begin
            grant_s = req;
        end
    end

    assign grant = grant_s;
    assign upd   = |grant_s;

    // Remember the winner of each accepted handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= 1'b1;
        end else if (upd) begin
            last_grant_r <= grant_s[1];
        end
    end

endmodule

// File: rtl/aes_dp_sched.sv
// Shares one AES round datapath between the hash-subkey (req0) and counter-block (req1) paths.
// Optional watchdog abort of a stalled datapath: define AES_SCHED_TMO_EN.
module aes_dp_sched #(
    parameter int RND_SIZE = 128,
    parameter int NUM_RND  = 10,
    parameter int TMO_CYC  = 32,
    parameter int TMO_SIZE = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req0_valid,
    input  logic [RND_SIZE-1:0] i_req0_text,
    output logic                o_req0_ready,
    input  logic                i_req1_valid,
    input  logic [RND_SIZE-1:0] i_req1_text,
    output logic                o_req1_ready,
    input  logic [RND_SIZE-1:0] i_key,
    output logic                o_dp_en,
    output logic [RND_SIZE-1:0] o_dp_text,
    output logic [RND_SIZE-1:0] o_dp_key,
    input  logic [RND_SIZE-1:0] i_dp_cypher,
    input  logic                i_dp_flag,
    output logic                o_res_valid,
    output logic [RND_SIZE-1:0] o_res_data,
    output logic                o_res_id,
    input  logic                i_res_ready,
    output logic                o_busy,
    output logic                o_err
);
    import aes_pkg::*;

    sched_state_t        state_r;
    logic [1:0]          grant_s;
    logic                acc_s;
    logic                idle_s;
    logic                dp_en_r;
    logic                res_valid_r;
    logic [RND_SIZE-1:0] dp_text_r;
    logic [RND_SIZE-1:0] dp_key_r;
    logic [RND_SIZE-1:0] res_data_r;
    req_id_t             id_r;
    req_id_t             res_id_r;
    logic                unused_num_rnd_s;

    assign idle_s = (state_r == IDLE);

    aes_rr_arb u_arb (
        .clk   (clk),
        .rst   (rst),
        .req   ({i_req1_valid, i_req0_valid}),
        .en    (idle_s),
        .grant (grant_s),
        .upd   (acc_s)
    );

    assign o_req0_ready = grant_s[0];
    assign o_req1_ready = grant_s[1];
    assign o_dp_en      = dp_en_r;
    assign o_dp_text    = dp_text_r;
    assign o_dp_key     = dp_key_r;
    assign o_res_valid  = res_valid_r;
    assign o_res_data   = res_data_r;
    assign o_res_id     = res_id_r;
    assign o_busy       = !idle_s;

    // NUM_RND documents the expected datapath latency; the scheduler simply waits for the flag.
    assign unused_num_rnd_s = NUM_RND[0];

`ifdef AES_SCHED_TMO_EN
    logic [TMO_SIZE-1:0] tmo_cnt_r;
    logic                err_r;
    logic                tmo_hit_s;

    assign tmo_hit_s = (tmo_cnt_r == TMO_SIZE'(TMO_CYC - 1));
    assign o_err     = err_r;
`else
    logic unused_tmo_s;

    assign unused_tmo_s = ^{TMO_CYC[0], TMO_SIZE[0]};
    assign o_err        = 1'b0;
`endif

    // Scheduler FSM: load on acceptance, run until the done flag, hold the result until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            dp_en_r     <= 1'b0;
            res_valid_r <= 1'b0;
            dp_text_r   <= {RND_SIZE{1'b0}};
            dp_key_r    <= {RND_SIZE{1'b0}};
            res_data_r  <= {RND_SIZE{1'b0}};
            id_r        <= 1'b0;
            res_id_r    <= 1'b0;
`ifdef AES_SCHED_TMO_EN
            tmo_cnt_r   <= {TMO_SIZE{1'b0}};
            err_r       <= 1'b0;
`endif
        end else begin
`ifdef AES_SCHED_TMO_EN
            err_r <= 1'b0;
`endif
            case (state_r)
                IDLE: begin
                    if (acc_s) begin
                        dp_text_r <= grant_s[1] ? i_req1_text : i_req0_text;
                        dp_key_r  <= i_key;
                        id_r      <= grant_s[1];
                        dp_en_r   <= 1'b1;
                        state_r   <= RUN;
`ifdef AES_SCHED_TMO_EN
                        tmo_cnt_r <= {TMO_SIZE{1'b0}};
`endif
                    end
                end
                RUN: begin
                    if (i_dp_flag) begin
                        res_data_r  <= i_dp_cypher;
                        res_id_r    <= id_r;
                        res_valid_r <= 1'b1;
                        dp_en_r     <= 1'b0;
                        state_r     <= DONE;
                    end
`ifdef AES_SCHED_TMO_EN
                    else if (tmo_hit_s) begin
                        dp_en_r <= 1'b0;
                        err_r   <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + {{(TMO_SIZE-1){1'b0}}, 1'b1};
                    end
`endif
                end
                DONE: begin
                    if (i_res_ready) begin
                        res_valid_r <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    dp_en_r     <= 1'b0;
                    res_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aes_dp_sched.md
Name: aes_dp_sched

Overview:
Scheduler that shares one AES round datapath (aes_data_path) between two requesters in the GCM engine: req0 is the hash-subkey path (H = E_K(0^128)) and req1 is the counter-block path (E_K(Y_i)). It arbitrates round-robin, loads the text and key, holds the datapath enable until the done flag, and returns the result with a tag identifying the requester over a valid/ready channel.

Parameters:
RND_SIZE, 128, block/key width in bits
NUM_RND, 10, AES rounds; nominal datapath latency in cycles
TMO_CYC, 32, watchdog limit in cycles (used only with AES_SCHED_TMO_EN)
TMO_SIZE, 6, watchdog counter width

Ports:
clk  in  1  sole clock, rising edge
rst  in  1  asynchronous, active-high reset
i_req0_valid  in  1  req0 block offered
i_req0_text  in  RND_SIZE  req0 plaintext block
o_req0_ready  out  1  req0 accepted this cycle
i_req1_valid  in  1  req1 block offered
i_req1_text  in  RND_SIZE  req1 plaintext block
o_req1_ready  out  1  req1 accepted this cycle
i_key  in  RND_SIZE  cipher key, sampled at acceptance
o_dp_en  out  1  datapath enable (level)
o_dp_text  out  RND_SIZE  registered text to datapath
o_dp_key  out  RND_SIZE  registered key to datapath
i_dp_cypher  in  RND_SIZE  datapath result
i_dp_flag  in  1  datapath done pulse
o_res_valid  out  1  result available
o_res_data  out  RND_SIZE  result block
o_res_id  out  1  0 = req0, 1 = req1
i_res_ready  in  1  consumer accepts result
o_busy  out  1  state != IDLE
o_err  out  1  watchdog abort pulse (tied 0 without AES_SCHED_TMO_EN)

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset: state IDLE; o_dp_en, o_res_valid, o_busy, o_err = 0; o_dp_text, o_dp_key, o_res_data = 0; o_res_id = 0; last_grant = 1, so req0 wins first.
- FSM states: IDLE, RUN, DONE.
- IDLE: the ready outputs are combinational. If exactly one valid is high, that requester's ready is 1. If both are high, the requester not equal to last_grant gets ready. At most one ready is high per cycle. On valid&ready: register text, i_key and id, update last_grant, then RUN next cycle.
- RUN: o_dp_en = 1 from the first RUN cycle. On i_dp_flag: o_res_data <= i_dp_cypher, o_res_id <= id, o_res_valid <= 1, o_dp_en <= 0, then DONE.
- Latency: acceptance edge to o_res_valid is NUM_RND + 2 cycles with a datapath of NUM_RND-cycle latency.
- DONE: o_res_valid, o_res_data and o_res_id are held stable until i_res_ready. On the handshake, o_res_valid <= 0 and the FSM goes to IDLE. A new acceptance is possible the next cycle. No acceptance occurs in RUN or DONE; both readys are 0.
- i_dp_flag outside RUN is ignored. i_key changes after acceptance have no effect on the operation in flight.
- Requester valids may drop without a handshake; no state change results.
- Reset mid-RUN or mid-DONE aborts immediately: the result is lost, o_dp_en drops asynchronously, and last_grant returns to 1.

Optional Feature:
AES_SCHED_TMO_EN.
- Defined: a TMO_SIZE-bit counter clears on entry to RUN and increments each RUN cycle without a flag. When it reaches TMO_CYC-1 with no flag: o_dp_en <= 0, o_err pulses for 1 cycle, state goes to IDLE, and no result is produced. last_grant still advances.
- Undefined: RUN waits indefinitely, and o_err is tied 0.

Decomposition:
- Package aes_pkg: RND_SIZE and NUM_RND constants, the sched_state_t enum (IDLE/RUN/DONE), and a req_id_t 1-bit typedef.
- Sub-module aes_rr_arb: a 2-way round-robin grant with a last_grant register. Inputs are req[1:0] and an enable (state == IDLE). Outputs are a one-hot grant and an update strobe.

Test Plan:
Bench datapath model: asserts i_dp_flag NUM_RND cycles after o_dp_en rises and returns text XOR key. Key for all scenarios: 000102030405060708090a0b0c0d0e0f.
1. Reset then single req0 with text 00112233445566778899aabbccddeeff -> o_req0_ready for 1 cycle; o_res_valid 12 cycles later with data 00102030405060708090a0b0c0d0e0f0 and id 0.
2. Both valid continuously for 4 operations -> grant order 0, 1, 0, 1; o_res_id matches; never both readys high.
3. i_res_ready held low 5 cycles in DONE -> result stable, both readys 0; after ready, acceptance in the next cycle.
4. rst asserted 3 cycles into RUN -> o_dp_en and o_busy 0 immediately; after release, a new req1 completes normally with req0 still favoured on tie.
5. i_dp_flag pulsed in IDLE and i_key changed mid-RUN -> no result from the stray flag; the result uses the key sampled at acceptance.
6. (AES_SCHED_TMO_EN) model never flags -> o_err pulses after TMO_CYC RUN cycles, the FSM returns to IDLE, no o_res_valid, and the next request completes.
